// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes and mux selects.
// Also defines the packed control word driven to the datapath.
package control_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StRwb      = 4'd7,
        StExecI    = 4'd8,
        StIwb      = 4'd9,
        StBranch   = 4'd10,
        StJump     = 4'd11,
        StHalt     = 4'd12,
        StTrap     = 4'd13
    } state_t;

    localparam logic [3:0] OpRType = 4'd0;
    localparam logic [3:0] OpAddi  = 4'd1;
    localparam logic [3:0] OpLw    = 4'd2;
    localparam logic [3:0] OpSw    = 4'd3;
    localparam logic [3:0] OpBeq   = 4'd4;
    localparam logic [3:0] OpBne   = 4'd5;
    localparam logic [3:0] OpJ     = 4'd6;
    localparam logic [3:0] OpHalt  = 4'd15;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] SrcBRegB   = 2'b00;
    localparam logic [1:0] SrcBConst2 = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmShl = 2'b11;

    localparam logic [1:0] PcDataAlu    = 2'b00;
    localparam logic [1:0] PcDataAluOut = 2'b01;
    localparam logic [1:0] PcDataJump   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       sign_ext;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ireg_write;
        logic       greg_write;
        logic       write_addr;
        logic       write_data;
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic [1:0] pc_data;
        logic       halted;
        logic       trap;
    } ctrl_t;

endpackage

// File: rtl/control_output_decode.sv
// Combinational state -> control word decoder (Moore outputs), also used by the trace monitor.
module control_output_decode
    import control_pkg::*;
(
    input  logic [3:0] state,
    input  logic       is_beq,
    input  logic       is_bne,
    input  logic       mem_ready,
    input  logic       reset,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            StFetch: begin
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src_b  = SrcBConst2;
                ctrl.alu_op     = AluAdd;
                ctrl.pc_data    = PcDataAlu;
                ctrl.ireg_write = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            StDecode: begin
                ctrl.alu_src_b = SrcBImmShl;
                ctrl.sign_ext  = 1'b1;
            end
            StMemAddr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.sign_ext  = 1'b1;
            end
            StMemRead: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            StMemWb: begin
                ctrl.greg_write = 1'b1;
                ctrl.write_data = 1'b1;
                ctrl.write_addr = 1'b1;
            end
            StMemWrite: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            StExecR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBRegB;
                ctrl.alu_op    = AluFunct;
            end
            StRwb: ctrl.greg_write = 1'b1;
            StExecI: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.sign_ext  = 1'b1;
            end
            StIwb: begin
                ctrl.greg_write = 1'b1;
                ctrl.write_addr = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = SrcBRegB;
                ctrl.alu_op       = AluSub;
                ctrl.pc_data      = PcDataAluOut;
                ctrl.pc_write_beq = is_beq;
                ctrl.pc_write_bne = is_bne;
            end
            StJump: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_data  = PcDataJump;
            end
            StHalt: ctrl.halted = 1'b1;
            StTrap: ctrl.trap = 1'b1;
            default: ;
        endcase

        // Architectural state must not change while reset is held.
        ctrl.ireg_write = ctrl.ireg_write & ~reset;
        ctrl.pc_write   = ctrl.pc_write & ~reset;
        ctrl.mem_write  = ctrl.mem_write & ~reset;
        ctrl.greg_write = ctrl.greg_write & ~reset;
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: state register and next-state logic; outputs come from the decoder.
module multicycle_control_fsm
    import control_pkg::*;
#(
    parameter int unsigned OPCODE_W      = 4,
    parameter bit          MEM_HANDSHAKE = 1'b1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                MemReady,
    output logic [1:0]          ALUOp,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic                SignExt,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRegWrite,
    output logic                GRegWrite,
    output logic                WriteAddr,
    output logic                WriteData,
    output logic                PCWrite,
    output logic                PCWriteBeq,
    output logic                PCWriteBne,
    output logic [1:0]          PCData,
    output logic [3:0]          current_state,
    output logic [3:0]          next_state,
    output logic                halted,
    output logic                trap
);

    state_t     state_q, state_d;
    logic [3:0] opc_lo;
    logic       opc_hi_set;
    logic       mem_ready;
    ctrl_t      ctrl;

    assign opc_lo    = Opcode[3:0];
    assign mem_ready = MemReady | ~MEM_HANDSHAKE;

    if (OPCODE_W > 4) begin : gen_wide_opcode
        assign opc_hi_set = |Opcode[OPCODE_W-1:4];
    end else begin : gen_narrow_opcode
        assign opc_hi_set = 1'b0;
    end

    always_ff @(posedge CLK) begin
        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                if (opc_hi_set) begin
                    state_d = StTrap;
                end else begin
                    case (opc_lo)
                        OpRType:    state_d = StExecR;
                        OpAddi:     state_d = StExecI;
                        OpLw, OpSw: state_d = StMemAddr;
                        OpBeq, OpBne: state_d = StBranch;
                        OpJ:        state_d = StJump;
                        OpHalt:     state_d = StHalt;
                        default:    state_d = StTrap;
                    endcase
                end
            end
            // Opcode is held stable, so anything other than LW/SW here is a corrupted IR.
            StMemAddr: begin
                if (!opc_hi_set && opc_lo == OpLw)      state_d = StMemRead;
                else if (!opc_hi_set && opc_lo == OpSw) state_d = StMemWrite;
                else                                    state_d = StTrap;
            end
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecR:    state_d = StRwb;
            StExecI:    state_d = StIwb;
            StMemWb, StRwb, StIwb, StBranch, StJump: state_d = StFetch;
            StHalt:     state_d = StHalt;
            StTrap:     state_d = StTrap;
            default:    state_d = StTrap;
        endcase
        if (Reset) state_d = StFetch;
    end

    control_output_decode u_decode (
        .state     (state_q),
        .is_beq    (!opc_hi_set && opc_lo == OpBeq),
        .is_bne    (!opc_hi_set && opc_lo == OpBne),
        .mem_ready (mem_ready),
        .reset     (Reset),
        .ctrl      (ctrl)
    );

    assign ALUOp         = ctrl.alu_op;
    assign ALUSrcA       = ctrl.alu_src_a;
    assign ALUSrcB       = ctrl.alu_src_b;
    assign SignExt       = ctrl.sign_ext;
    assign IorD          = ctrl.iord;
    assign MemRead       = ctrl.mem_read;
    assign MemWrite      = ctrl.mem_write;
    assign IRegWrite     = ctrl.ireg_write;
    assign GRegWrite     = ctrl.greg_write;
    assign WriteAddr     = ctrl.write_addr;
    assign WriteData     = ctrl.write_data;
    assign PCWrite       = ctrl.pc_write;
    assign PCWriteBeq    = ctrl.pc_write_beq;
    assign PCWriteBne    = ctrl.pc_write_bne;
    assign PCData        = ctrl.pc_data;
    assign halted        = ctrl.halted;
    assign trap          = ctrl.trap;
    assign current_state = state_q;
    assign next_state    = state_d;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed and random instruction streams against a trace model.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       sign_ext;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ireg_write;
        logic       greg_write;
        logic       write_addr;
        logic       write_data;
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic [1:0] pc_data;
        logic       halted;
        logic       trap;
    } ctl_t;

    typedef struct {
        int s;
        bit rdy;
    } step_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // dut0: 5-bit opcode, handshake honoured
    logic       rst0 = 1'b1, rdy0 = 1'b1;
    logic [4:0] op0 = '0;
    logic [1:0] d0_alu_op, d0_src_b, d0_pc_data;
    logic       d0_src_a, d0_sext, d0_iord, d0_mrd, d0_mwr, d0_irw, d0_grw, d0_waddr, d0_wdata;
    logic       d0_pcw, d0_beq, d0_bne, d0_halted, d0_trap;
    logic [3:0] d0_state, d0_next;
    ctl_t       obs0;

    // dut1: 4-bit opcode, handshake disabled, MemReady tied low
    logic       rst1 = 1'b1;
    logic [3:0] op1 = '0;
    logic [1:0] d1_alu_op, d1_src_b, d1_pc_data;
    logic       d1_src_a, d1_sext, d1_iord, d1_mrd, d1_mwr, d1_irw, d1_grw, d1_waddr, d1_wdata;
    logic       d1_pcw, d1_beq, d1_bne, d1_halted, d1_trap;
    logic [3:0] d1_state, d1_next;
    ctl_t       obs1;

    multicycle_control_fsm #(.OPCODE_W(5), .MEM_HANDSHAKE(1'b1)) dut0 (
        .CLK(CLK), .Reset(rst0), .Opcode(op0), .MemReady(rdy0),
        .ALUOp(d0_alu_op), .ALUSrcA(d0_src_a), .ALUSrcB(d0_src_b), .SignExt(d0_sext),
        .IorD(d0_iord), .MemRead(d0_mrd), .MemWrite(d0_mwr), .IRegWrite(d0_irw),
        .GRegWrite(d0_grw), .WriteAddr(d0_waddr), .WriteData(d0_wdata), .PCWrite(d0_pcw),
        .PCWriteBeq(d0_beq), .PCWriteBne(d0_bne), .PCData(d0_pc_data),
        .current_state(d0_state), .next_state(d0_next), .halted(d0_halted), .trap(d0_trap)
    );

    multicycle_control_fsm #(.OPCODE_W(4), .MEM_HANDSHAKE(1'b0)) dut1 (
        .CLK(CLK), .Reset(rst1), .Opcode(op1), .MemReady(1'b0),
        .ALUOp(d1_alu_op), .ALUSrcA(d1_src_a), .ALUSrcB(d1_src_b), .SignExt(d1_sext),
        .IorD(d1_iord), .MemRead(d1_mrd), .MemWrite(d1_mwr), .IRegWrite(d1_irw),
        .GRegWrite(d1_grw), .WriteAddr(d1_waddr), .WriteData(d1_wdata), .PCWrite(d1_pcw),
        .PCWriteBeq(d1_beq), .PCWriteBne(d1_bne), .PCData(d1_pc_data),
        .current_state(d1_state), .next_state(d1_next), .halted(d1_halted), .trap(d1_trap)
    );

    assign obs0 = {d0_alu_op, d0_src_a, d0_src_b, d0_sext, d0_iord, d0_mrd, d0_mwr, d0_irw,
                   d0_grw, d0_waddr, d0_wdata, d0_pcw, d0_beq, d0_bne, d0_pc_data, d0_halted,
                   d0_trap};
    assign obs1 = {d1_alu_op, d1_src_a, d1_src_b, d1_sext, d1_iord, d1_mrd, d1_mwr, d1_irw,
                   d1_grw, d1_waddr, d1_wdata, d1_pcw, d1_beq, d1_bne, d1_pc_data, d1_halted,
                   d1_trap};

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cur_s   = 0;
    step_t tr[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected control word for a phase, written from the per-state output table.
    function automatic ctl_t exp_ctl(input int s, input logic [4:0] op, input bit rdy,
                                     input bit rst);
        ctl_t c;
        c = '0;
        case (s)
            0: begin
                c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ireg_write = rdy; c.pc_write = rdy;
            end
            1: begin c.alu_src_b = 2'b11; c.sign_ext = 1'b1; end
            2: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.sign_ext = 1'b1; end
            3: begin c.mem_read = 1'b1; c.iord = 1'b1; end
            4: begin c.greg_write = 1'b1; c.write_data = 1'b1; c.write_addr = 1'b1; end
            5: begin c.mem_write = 1'b1; c.iord = 1'b1; end
            6: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            7: c.greg_write = 1'b1;
            8: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.sign_ext = 1'b1; end
            9: begin c.greg_write = 1'b1; c.write_addr = 1'b1; end
            10: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_data = 2'b01;
                c.pc_write_beq = (op == 5'd4); c.pc_write_bne = (op == 5'd5);
            end
            11: begin c.pc_write = 1'b1; c.pc_data = 2'b10; end
            12: c.halted = 1'b1;
            13: c.trap = 1'b1;
            default: ;
        endcase
        if (rst) begin
            c.ireg_write = 1'b0; c.pc_write = 1'b0; c.mem_write = 1'b0; c.greg_write = 1'b0;
        end
        return c;
    endfunction

    function automatic void push(input int s, input bit r);
        step_t e;
        e.s = s;
        e.rdy = r;
        tr.push_back(e);
    endfunction

    // Build the phase trace of one instruction; term=1 when it ends in a sticky state.
    function automatic bit build(input logic [4:0] op, input int fstall, input int mstall);
        int kind;
        tr.delete();
        for (int i = 0; i < fstall; i++) push(0, 1'b0);
        push(0, 1'b1);
        push(1, 1'b0);
        kind = op[4] ? 99 : int'(op[3:0]);
        case (kind)
            0: begin push(6, 1'b0); push(7, 1'b0); end
            1: begin push(8, 1'b0); push(9, 1'b0); end
            2: begin
                push(2, 1'b0);
                for (int i = 0; i < mstall; i++) push(3, 1'b0);
                push(3, 1'b1); push(4, 1'b0);
            end
            3: begin
                push(2, 1'b0);
                for (int i = 0; i < mstall; i++) push(5, 1'b0);
                push(5, 1'b1);
            end
            4, 5: push(10, 1'b0);
            6: push(11, 1'b0);
            15: begin for (int i = 0; i < 5; i++) push(12, 1'b0); return 1'b1; end
            default: begin for (int i = 0; i < 5; i++) push(13, 1'b0); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    task automatic run_instr(input logic [4:0] op, input int fstall, input int mstall,
                             input int abort_at);
        bit term;
        int n;
        term = build(op, fstall, mstall);
        n = (abort_at >= 0 && abort_at < tr.size()) ? abort_at : tr.size();
        for (int i = 0; i < n; i++) begin
            int s;
            int nx;
            bit r;
            s = tr[i].s;
            r = (s == 0 || s == 3 || s == 5) ? tr[i].rdy : 1'($urandom);
            rdy0 = r;
            op0 = (s == 0) ? 5'($urandom) : op;
            nx = (i + 1 < tr.size()) ? tr[i + 1].s : (term ? s : 0);
            @(negedge CLK);
            chk($sformatf("state op=%0d step=%0d", op, i), 32'(d0_state), 32'(s));
            chk($sformatf("ctl op=%0d step=%0d", op, i), 32'(obs0),
                32'(exp_ctl(s, op, r, 1'b0)));
            chk($sformatf("next op=%0d step=%0d", op, i), 32'(d0_next), 32'(nx));
            @(posedge CLK);
            #1;
        end
        cur_s = (n < tr.size()) ? tr[n].s : (term ? tr[n - 1].s : 0);
    endtask

    task automatic do_reset(input bit check_pre);
        rst0 = 1'b1;
        rdy0 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            if (k > 0 || check_pre) begin
                chk($sformatf("rst state k=%0d", k), 32'(d0_state), 32'(cur_s));
                chk($sformatf("rst ctl k=%0d", k), 32'(obs0),
                    32'(exp_ctl(cur_s, op0, 1'b1, 1'b1)));
                chk($sformatf("rst next k=%0d", k), 32'(d0_next), 32'd0);
            end
            @(posedge CLK);
            #1;
            cur_s = 0;
        end
        rst0 = 1'b0;
    endtask

    initial begin
        int r1_seq[6];
        do_reset(1'b0);

        run_instr(5'd2, 0, 0, -1);            // LW, no stalls
        run_instr(5'd3, 0, 3, -1);            // SW, 3 stall cycles
        run_instr(5'd4, 0, 0, -1);            // BEQ
        run_instr(5'd5, 0, 0, -1);            // BNE
        run_instr(5'd9, 0, 0, -1);            // illegal -> TRAP
        do_reset(1'b1);
        run_instr(5'd15, 1, 0, -1);           // HALT
        do_reset(1'b1);
        run_instr(5'd16, 0, 0, -1);           // high opcode bit -> TRAP
        do_reset(1'b1);
        run_instr(5'd18, 0, 0, -1);
        do_reset(1'b1);
        run_instr(5'd3, 0, 3, 4);             // reset mid MEMWRITE stall
        do_reset(1'b1);
        run_instr(5'd1, 2, 0, -1);
        run_instr(5'd0, 0, 0, -1);
        run_instr(5'd6, 0, 0, -1);
        run_instr(5'd2, 1, 2, -1);

        for (int t = 0; t < 40; t++) begin
            logic [4:0] op;
            int pick;
            int abort;
            pick = int'($urandom_range(0, 19));
            if (pick < 14)      op = 5'(pick % 7);
            else if (pick < 16) op = 5'd15;
            else if (pick < 18) op = 5'($urandom_range(7, 14));
            else                op = 5'($urandom_range(16, 31));
            abort = -1;
            if ($urandom_range(0, 7) == 0) abort = int'($urandom_range(0, 4));
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), abort);
            if (cur_s != 0) do_reset(1'b1);
        end

        // Handshake disabled: R-type runs FETCH, DECODE, EXEC_R, RWB with MemReady low.
        r1_seq = '{0, 1, 6, 7, 0, 1};
        op1 = 4'd0;
        @(posedge CLK);
        #1;
        rst1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("nohs state step=%0d", i), 32'(d1_state), 32'(r1_seq[i]));
            chk($sformatf("nohs ctl step=%0d", i), 32'(obs1),
                32'(exp_ctl(r1_seq[i], 5'd0, 1'b1, 1'b0)));
            chk($sformatf("nohs next step=%0d", i), 32'(d1_next), 32'(r1_seq[i + 1]));
            @(posedge CLK);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised multicycle control unit for the 16-bit datapath. Generalises the fixed 4-bit-opcode controller.
- Moore FSM that sequences fetch/decode/execute/memory/writeback and drives every datapath mux select and write enable.
- New relative to the previous generation:
  - optional memory-ready stall handshake;
  - 2-bit ALUSrcB and PCData selects;
  - HALT and illegal-opcode TRAP states;
  - write-enable suppression while reset is held.
- Sits between the instruction register's opcode field and the datapath/memory.

Parameters:
- OPCODE_W, 4, opcode width. Must be ≥4. Any set bit above bit 3 makes the opcode illegal.
- MEM_HANDSHAKE, 1, 1 = honour MemReady; 0 = MemReady is internally forced to 1.

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- Opcode  in  OPCODE_W  from IR; held stable from DECODE until the next FETCH
- MemReady  in  1  memory has completed the current access this cycle
- ALUOp  out  2  00 add, 01 sub, 10 use funct
- ALUSrcA  out  1  0 PC, 1 regA
- ALUSrcB  out  2  00 regB, 01 const 2, 10 imm, 11 imm<<1
- SignExt  out  1  sign-extend immediate
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- MemRead, MemWrite  out  1 each
- IRegWrite  out  1  IR load
- GRegWrite  out  1  register file write
- WriteAddr  out  1  dest: 0 rd field, 1 rt field
- WriteData  out  1  0 ALUOut, 1 MDR
- PCWrite, PCWriteBeq, PCWriteBne  out  1 each
- PCData  out  2  00 ALU result, 01 ALUOut, 10 jump target
- current_state, next_state  out  4  debug visibility
- halted, trap  out  1 each

Behaviour:
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADDR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE, 6 EXEC_R, 7 RWB
  - 8 EXEC_I, 9 IWB, 10 BRANCH, 11 JUMP, 12 HALT, 13 TRAP
  - 14 and 15 are unreachable; if entered, next_state = TRAP.
- Opcodes (low 4 bits): 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 J, 15 HALT. All others are illegal.
- Output rules:
  - Outputs are a combinational decode of current_state; unlisted outputs are 0.
  - Write enables IRegWrite, PCWrite, MemWrite and GRegWrite are additionally ANDed with !Reset.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCData=00.
  - IRegWrite = PCWrite = MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, SignExt=1, ALUOp=00 (branch target into ALUOut).
  - Dispatch: R→EXEC_R, ADDI→EXEC_I, LW/SW→MEMADDR, BEQ/BNE→BRANCH, J→JUMP, HALT→HALT, illegal→TRAP.
- MEMADDR:
  - Drives ALUSrcA=1, ALUSrcB=10, SignExt=1.
  - LW→MEMREAD, SW→MEMWRITE.
- MEMREAD:
  - Drives MemRead=1, IorD=1.
  - Waits for MemReady, then →MEMWB.
- MEMWB:
  - Drives GRegWrite=1, WriteData=1, WriteAddr=1.
  - →FETCH.
- MEMWRITE:
  - Drives MemWrite=1, IorD=1. MemWrite stays high through stall cycles.
  - →FETCH on MemReady.
- EXEC_R:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - →RWB.
- RWB:
  - Drives GRegWrite=1, WriteAddr=0, WriteData=0.
  - →FETCH.
- EXEC_I:
  - Drives ALUSrcA=1, ALUSrcB=10, SignExt=1.
  - →IWB.
- IWB:
  - Drives GRegWrite=1, WriteAddr=1.
  - →FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCData=01.
  - PCWriteBeq=1 for BEQ, PCWriteBne=1 for BNE.
  - →FETCH.
- JUMP:
  - Drives PCWrite=1, PCData=10.
  - →FETCH.
- HALT: halted=1; self-loop until Reset.
- TRAP: trap=1; self-loop until Reset.
- Reset:
  - A rising edge with Reset=1 loads FETCH from any state, including mid-stall.
  - During Reset, next_state reports FETCH.
- Instruction latency in cycles with no stalls:
  - R/ADDI/LW = 4/4/5
  - SW = 4
  - BEQ/BNE/J = 3
  - Each stall cycle adds 1.

Decomposition:
- Package control_pkg holds:
  - state enum/localparams;
  - opcode localparams;
  - ALUOp, ALUSrcB and PCData encodings.
- Sub-module control_output_decode: purely combinational state→control-word decoder, shared with the disassembler/trace monitor.
- The FSM register and next-state logic stay in multicycle_control_fsm.

Test Plan:
- Reset held 2 cycles from an arbitrary state:
  - current_state=0 after the first edge;
  - PCWrite, IRegWrite, MemWrite and GRegWrite are all 0 while Reset=1.
- LW (Opcode=2) with MemReady=1:
  - state sequence 0,1,2,3,4,0;
  - GRegWrite=1 and WriteData=1 only in state 4.
- SW (Opcode=3) with MemReady held low for 3 cycles in MEMWRITE:
  - 3 extra cycles in state 5 with MemWrite=1;
  - returns to 0 one edge after MemReady=1.
- BEQ (Opcode=4) then BNE (Opcode=5):
  - state 10 asserts PCWriteBeq only, then PCWriteBne only;
  - ALUOp=01 and PCData=01 in both.
- Opcode=9:
  - TRAP (13), trap=1, stays in TRAP across 5 cycles;
  - Reset returns to 0.
- Opcode=15: HALT (12), halted=1.
- MEM_HANDSHAKE=0 with MemReady tied 0: R-type (Opcode=0) completes in 4 cycles (0,1,6,7).
